// File: rtl/demux_sched_pkg.sv
// Shared types, sizes and the round-robin channel search used by the
// 1-to-4 demux scheduler.
package demux_sched_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } sched_state_t;

  // First channel whose skip bit is clear, searched cur+1, cur+2, cur+3, cur
  // (mod NCH), or 0..NCH-1 when from_zero is set. Falls back to cur when all
  // channels are skipped.
  function automatic logic [SEL_W-1:0] next_rr_chan(
    input logic [SEL_W-1:0] cur,
    input logic [NCH-1:0]   skip,
    input logic             from_zero
  );
    logic [SEL_W-1:0] cand;
    logic             found;
    next_rr_chan = cur;
    found        = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      cand = from_zero ? SEL_W'(k) : SEL_W'(cur + SEL_W'(k + 1));
      if (!found && !skip[cand]) begin
        next_rr_chan = cand;
        found        = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/demux_decode_1to4.sv
// Combinational 1-to-4 demux decode: enable plus select to a one-hot valid.
module demux_decode_1to4
  import demux_sched_pkg::*;
(
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [NCH-1:0]   out_valid
);

  always_comb begin
    out_valid = '0;
    if (en) out_valid[sel] = 1'b1;
  end

endmodule

// File: rtl/demux_chan_scheduler.sv
// Steers a single valid/ready word stream onto one of four demux channels
// through a one-word holding stage, in round-robin bursts or a fixed channel.
module demux_chan_scheduler
  import demux_sched_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BURST  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_mode,
  input  logic [SEL_W-1:0]  cfg_fix_sel,
  input  logic [NCH-1:0]    cfg_skip,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic [SEL_W-1:0]  sel,
  output logic              en,
  output logic [7:0]        burst_cnt
);

  localparam logic [7:0] BURST_LAST = 8'(BURST - 1);

  sched_state_t      state_q, state_nxt;
  logic [DATA_W-1:0] data_q;
  logic [SEL_W-1:0]  sel_q, sel_nxt;
  logic [7:0]        cnt_q;
  logic              rr_started_q;

  logic chan_ok;
  logic drain;
  logic accept;
  logic commit;

  // Handshake: a full stage can take a new word in the same cycle it drains.
  always_comb begin
    chan_ok  = cfg_mode | (cfg_skip != '1);
    drain    = (state_q == FULL) & out_ready[sel_q];
    in_ready = chan_ok & ((state_q == EMPTY) | drain);
    accept   = in_valid & in_ready;
    commit   = accept & (cnt_q == 8'd0);
    sel_nxt  = cfg_mode ? cfg_fix_sel
                        : next_rr_chan(sel_q, cfg_skip, ~rr_started_q);
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      EMPTY: if (accept) state_nxt = FULL;
      FULL:  if (drain && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      data_q       <= '0;
      sel_q        <= '0;
      cnt_q        <= '0;
      rr_started_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (accept) begin
        data_q <= in_data;
        cnt_q  <= (cnt_q == BURST_LAST) ? 8'd0 : cnt_q + 8'd1;
      end
      // Channel only moves at a burst boundary, when the stage is being reloaded.
      if (commit) begin
        sel_q <= sel_nxt;
        if (!cfg_mode) rr_started_q <= 1'b1;
      end
    end
  end

  assign en        = (state_q == FULL);
  assign out_data  = data_q;
  assign sel       = sel_q;
  assign burst_cnt = cnt_q;

  demux_decode_1to4 u_decode (
    .en        (en),
    .sel       (sel_q),
    .out_valid (out_valid)
  );

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (en && !drain) |=> (en && $stable(sel) && $stable(out_data)));

  a_valid_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(out_valid));

endmodule
